inst_cache_responder: RTL
=========================

Name: inst_cache_responder

Overview:
Responder end of the CacheReq/CacheResp protocol that the instruction fetch queue drives as initiator. It is a direct-mapped, single-word-line instruction cache with one outstanding request. It sits between the fetch queue and backing memory, and acts as initiator on a second CacheReq/CacheResp pair toward that memory. Hits return one cycle after accept, and the block accepts a new request in the same cycle it returns a response, so the fetch queue can stream back-to-back.

Parameters:
INDEX_WIDTH, 6, log2 of entry count (64 entries); tag width = 30 - INDEX_WIDTH.

Ports:
clk  input  1  clock, all state on posedge.
rst_n  input  1  asynchronous, active-low reset.
creq  inout  CacheReq  upstream request: valid, addr[31:0], wen, wdata[31:0] are inputs; ready is an output.
cresp  inout  CacheResp  upstream response: valid and rdata[31:0] are outputs.
breq  inout  CacheReq  backing request: valid, addr, wen, wdata are outputs; ready is an input.
bresp  inout  CacheResp  backing response: valid and rdata are inputs.
perf_hits  output  32  hit counter (see Optional Feature).
perf_misses  output  32  miss counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all entry valid bits cleared; request register cleared.
  - cresp.valid=0, breq.valid=0, creq.ready=1 after release; perf counters=0.
  - Reset during a fill abandons the fill. Backing memory shares rst_n, so no stale bresp arrives after reset.
- Accept: a request is accepted when creq.valid && creq.ready. The block registers addr (with [1:0] forced to 0), wen and wdata, then enters LOOKUP.
- IDLE: ready=1.
- LOOKUP: compares the registered index entry valid and tag against the registered request.
  - Read hit: cresp.valid=1 and rdata=entry data in this cycle; ready=1. On a new accept go to LOOKUP, otherwise IDLE.
  - Read miss, or any write: ready=0, cresp.valid=0; go to MISS_REQ.
  - Write hit: entry data is updated with wdata in this cycle (write-through). Write miss: no allocate.
- MISS_REQ: breq.valid=1 with the registered addr, wen and wdata. When breq.ready=1, go to MISS_WAIT. breq fields stay stable while valid. ready=0.
- MISS_WAIT: breq.valid=0, ready=0. When bresp.valid=1:
  - For a read, latch bresp.rdata into the fill register and write the entry (valid=1, tag, data).
  - For a write, set the fill register to 0.
  - Go to RESP.
- RESP: cresp.valid=1 for exactly one cycle with rdata=fill register; ready=1. On a new accept go to LOOKUP, otherwise IDLE.
- cresp.valid is never high outside a LOOKUP hit or RESP. There is no backpressure on cresp: the initiator must sample it.
- A response is always delivered for every accepted request. The initiator discards stale ones after a kill.
- Latency:
  - Hit: accept at cycle T, response at T+1.
  - Miss: accept at T, breq.valid at T+2; response at X+1, where X is the bresp.valid cycle.
- Simultaneous events: a new request accepted in a LOOKUP-hit or RESP cycle to the same index as a just-filled entry sees the updated entry, because the array write lands at the same edge as the accept.
- breq.addr[1:0] is always 0. Upstream addr[1:0] is ignored.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined: perf_hits increments on each LOOKUP read hit; perf_misses increments on each LOOKUP read miss. Both are 32-bit and wrap at 2^32-1 to 0.
- Not defined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package icache_pkg holds:
  - state enum IcState {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP};
  - typedef IcEntry {valid, tag, data};
  - function TAG_W(INDEX_WIDTH).
- Sub-module icache_tag_array: flop-based array with valid/tag/data, one combinational read port, one write port and a clear-all on reset.
- The FSM and request register live in the top module.

Test Plan:
- After reset, read 0x100, with backing returning 0xDEADBEEF two cycles after breq accept → breq.addr=0x100; cresp.valid one cycle after bresp; rdata=0xDEADBEEF.
- Read 0x100 again, then back-to-back read 0x104 (prefilled) → responses on consecutive cycles with ready=1 throughout; no breq.
- Read 0x100, then read 0x200 (same index, INDEX_WIDTH=6, different tag) → miss and refill; a subsequent 0x100 read misses again.
- Write 0x100 with wdata 0x12345678 while cached → breq.wen=1; cresp.valid with rdata=0; next read of 0x100 hits with 0x12345678.
- Assert rst_n low during MISS_WAIT → all outputs reset immediately; the next read of the same address misses.
- ICACHE_PERF_EN defined: 3 hits and 2 misses → perf_hits=3, perf_misses=2. Undefined → both 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache responder.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    RESP
  } IcState;

  // Tag field is sized for the narrowest index; unused upper bits always hold zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] data;
  } IcEntry;

  function automatic int TAG_W(input int index_width);
    return 30 - index_width;
  endfunction

endpackage

// File: rtl/inst_cache_responder_if.sv
// CacheReq/CacheResp bus pair; "master" is always the initiator side of the pair.
interface CacheReq;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;

  modport master (output valid, output addr, output wen, output wdata, input ready);
  modport slave  (input valid, input addr, input wen, input wdata, output ready);
endinterface

interface CacheResp;
  logic        valid;
  logic [31:0] rdata;

  modport master (input valid, input rdata);
  modport slave  (output valid, output rdata);
endinterface

// File: rtl/inst_cache_responder_tag_array.sv
// Flop-based valid/tag/data store: one combinational read port, one write port.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output IcEntry                 rd_entry,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  IcEntry                 wr_entry
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DEPTH-1:0] valid_q;
  logic [29:0]      tag_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];

  // Only the valid bits need clearing; tag/data are ignored while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_entry.tag;
      data_q[wr_idx] <= wr_entry.data;
    end
  end

  always_comb begin
    rd_entry.valid = valid_q[rd_idx];
    rd_entry.tag   = tag_q[rd_idx];
    rd_entry.data  = data_q[rd_idx];
  end

endmodule

// File: rtl/inst_cache_responder.sv
// Direct-mapped single-word-line instruction cache, one outstanding request.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module inst_cache_responder
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  CacheReq.slave      creq,
  CacheResp.slave     cresp,
  CacheReq.master     breq,
  CacheResp.master    bresp,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
);

  localparam int TW = TAG_W(INDEX_WIDTH);

  IcState                 state;
  logic [29:0]            req_word;
  logic                   req_wen;
  logic [31:0]            req_wdata;
  logic [31:0]            fill_data;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TW-1:0]          req_tag;
  IcEntry                 rd_entry;
  IcEntry                 wr_entry;
  logic                   wr_en;
  logic                   tag_match;
  logic                   read_hit;
  logic                   up_ready;
  logic                   accept;

  assign req_idx   = req_word[INDEX_WIDTH-1:0];
  assign req_tag   = req_word[29:INDEX_WIDTH];
  assign tag_match = rd_entry.valid && (rd_entry.tag == 30'(req_tag));
  assign read_hit  = (state == LOOKUP) && !req_wen && tag_match;

  // Ready in a hit/RESP cycle lets the fetch queue stream one request per cycle.
  assign up_ready   = (state == IDLE) || (state == RESP) || read_hit;
  assign accept     = creq.valid && up_ready;
  assign creq.ready = up_ready;

  assign cresp.valid = read_hit || (state == RESP);
  assign cresp.rdata = read_hit ? rd_entry.data : fill_data;

  assign breq.valid = (state == MISS_REQ);
  assign breq.addr  = {req_word, 2'b00};
  assign breq.wen   = req_wen;
  assign breq.wdata = req_wdata;

  icache_tag_array #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_tag_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (req_idx),
    .rd_entry (rd_entry),
    .wr_en    (wr_en),
    .wr_idx   (req_idx),
    .wr_entry (wr_entry)
  );

  // Write-through update on a write hit; allocate only on read fills.
  always_comb begin
    wr_en          = 1'b0;
    wr_entry.valid = 1'b1;
    wr_entry.tag   = 30'(req_tag);
    wr_entry.data  = req_wdata;
    if ((state == LOOKUP) && req_wen && tag_match) begin
      wr_en = 1'b1;
    end else if ((state == MISS_WAIT) && bresp.valid && !req_wen) begin
      wr_en         = 1'b1;
      wr_entry.data = bresp.rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_word  <= '0;
      req_wen   <= 1'b0;
      req_wdata <= '0;
      fill_data <= '0;
    end else begin
      if (accept) begin
        req_word  <= creq.addr[31:2];
        req_wen   <= creq.wen;
        req_wdata <= creq.wdata;
      end
      case (state)
        IDLE: begin
          if (accept) state <= LOOKUP;
        end
        LOOKUP: begin
          if (read_hit) state <= accept ? LOOKUP : IDLE;
          else          state <= MISS_REQ;
        end
        MISS_REQ: begin
          if (breq.ready) state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (bresp.valid) begin
            fill_data <= req_wen ? 32'h0 : bresp.rdata;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= accept ? LOOKUP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic read_miss;

  assign read_miss = (state == LOOKUP) && !req_wen && !tag_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (read_hit)  perf_hits   <= perf_hits + 32'd1;
      if (read_miss) perf_misses <= perf_misses + 32'd1;
    end
  end
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule
